// File: rtl/dice_roller.sv
// Two-die roller: free-running face counters sampled on clock_en ticks after a roll press.
// Latency: ROLL_CYCLES enabled ticks of tumbling, then a single-cycle roll_done; presses while busy are dropped.
module dice_roller #(
  parameter int ROLL_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_en,
  input  logic       roll,
  output logic [2:0] dice1,
  output logic [2:0] dice2,
  output logic [3:0] sum,
  output logic       rolling,
  output logic       roll_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] c1_q, c1_d;
  logic [2:0] c2_q, c2_d;
  logic       roll_q, roll_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] dice1_q, dice1_d;
  logic [2:0] dice2_q, dice2_d;
  logic [3:0] sum_q, sum_d;
  logic       press;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dice1_d = dice1_q;
    dice2_d = dice2_q;
    sum_d   = sum_q;
    roll_d  = roll;
    press   = roll & ~roll_q;

    // Face counters run every clock so the press instant picks a uniform pair.
    c1_d = (c1_q == 3'd6) ? 3'd1 : c1_q + 3'd1;
    c2_d = c2_q;
    if (c1_q == 3'd6) begin
      c2_d = (c2_q == 3'd6) ? 3'd1 : c2_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = ROLLING;
          cnt_d   = 8'(ROLL_CYCLES - 1);
        end
      end
      ROLLING: begin
        if (clock_en) begin
          dice1_d = c1_q;
          dice2_d = c2_q;
          if (cnt_q == 8'd0) begin
            sum_d   = {1'b0, c1_q} + {1'b0, c2_q};
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      c1_q    <= 3'd1;
      c2_q    <= 3'd1;
      roll_q  <= 1'b0;
      cnt_q   <= 8'd0;
      dice1_q <= 3'd0;
      dice2_q <= 3'd0;
      sum_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      roll_q  <= roll_d;
      cnt_q   <= cnt_d;
      dice1_q <= dice1_d;
      dice2_q <= dice2_d;
      sum_q   <= sum_d;
    end
  end

  assign dice1     = dice1_q;
  assign dice2     = dice2_q;
  assign sum       = sum_q;
  assign rolling   = (state_q == ROLLING);
  assign roll_done = (state_q == DONE);

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: cycle-time reference model plus directed literal checks and random stimulus.
module tb_dice_roller;

  localparam int ROLL_CYCLES = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clock_en = 1'b0;
  logic       roll = 1'b0;
  logic [2:0] dice1;
  logic [2:0] dice2;
  logic [3:0] sum;
  logic       rolling;
  logic       roll_done;

  int checks = 0;
  int failures = 0;

  dice_roller #(.ROLL_CYCLES(ROLL_CYCLES)) dut (
    .clock     (clock),
    .reset     (reset),
    .clock_en  (clock_en),
    .roll      (roll),
    .dice1     (dice1),
    .dice2     (dice2),
    .sum       (sum),
    .rolling   (rolling),
    .roll_done (roll_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: faces derived from cycles elapsed since reset (36-cycle period),
  // roll tracked as a mode plus the number of enabled ticks still to latch.
  int m_t = 0;
  int m_mode = 0;       // 0 idle, 1 tumbling, 2 done pulse
  int m_left = 0;
  int m_prev_roll = 0;
  int m_d1 = 0, m_d2 = 0, m_sum = 0;
  bit m_valid = 0;

  always @(posedge clock) begin
    int f1, f2;
    if (reset) begin
      m_t = 0; m_mode = 0; m_left = 0; m_prev_roll = 0;
      m_d1 = 0; m_d2 = 0; m_sum = 0; m_valid = 1;
    end else begin
      f1 = (m_t % 6) + 1;
      f2 = ((m_t / 6) % 6) + 1;
      case (m_mode)
        0: if (roll && !m_prev_roll) begin m_mode = 1; m_left = ROLL_CYCLES; end
        1: if (clock_en) begin
             m_d1 = f1; m_d2 = f2; m_left--;
             if (m_left == 0) begin m_sum = f1 + f2; m_mode = 2; end
           end
        default: m_mode = 0;
      endcase
      m_prev_roll = roll;
      m_t = (m_t + 1) % 36;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_dice1", dice1, m_d1);
      chk("model_dice2", dice2, m_d2);
      chk("model_sum", sum, m_sum);
      chk("model_rolling", rolling, m_mode == 1);
      chk("model_roll_done", roll_done, m_mode == 2);
    end
  end

  initial begin
    int en_ticks, done_cnt;

    // T1/T2: reset, then hold roll high with clock_en tied high.
    @(posedge clock);
    @(negedge clock);
    chk("t1_dice1", dice1, 0);
    chk("t1_dice2", dice2, 0);
    chk("t1_sum", sum, 0);
    chk("t1_rolling", rolling, 0);
    chk("t1_roll_done", roll_done, 0);
    reset = 0; roll = 1; clock_en = 1;
    @(negedge clock);
    chk("t2_rolling_start", rolling, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t2_dice1", dice1, i + 2);
      chk("t2_dice2", dice2, 1);
    end
    chk("t2_sum", sum, 6);
    chk("t2_roll_done", roll_done, 1);
    chk("t2_rolling_end", rolling, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("t2_no_reroll", rolling | roll_done, 0);
    end

    // T3: clock_en every third cycle; exactly 4 enabled ticks while tumbling, one done pulse.
    roll = 0;
    @(negedge clock);
    roll = 1;
    en_ticks = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      clock_en = (i % 3 == 2);
      @(posedge clock);
      if (rolling && clock_en) en_ticks++;
      @(negedge clock);
      if (roll_done) done_cnt++;
    end
    chk("t3_enabled_ticks", en_ticks, 4);
    chk("t3_done_pulses", done_cnt, 1);

    // T6: reset on the second tumble tick, then a fresh roll from the still-held button.
    reset = 1; roll = 0; clock_en = 1;
    @(negedge clock);
    reset = 0; roll = 1;
    @(negedge clock);   // after press edge
    @(negedge clock);   // after tick 1
    reset = 1;
    @(negedge clock);   // after reset on tick 2
    chk("t6_rolling", rolling, 0);
    chk("t6_roll_done", roll_done, 0);
    chk("t6_dice1", dice1, 0);
    chk("t6_sum", sum, 0);
    reset = 0;
    @(negedge clock);   // press edge after reset
    chk("t6_restart", rolling, 1);
    @(negedge clock);
    chk("t6_dice1_first", dice1, 2);
    chk("t6_dice2_first", dice2, 1);
    for (int i = 0; i < 6; i++) @(negedge clock);

    // Random phase: button toggling (including during busy states), random enables, rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) roll = ~roll;
      clock_en = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clock);
      if (m_mode == 2) begin
        checks++;
        if (sum < 2 || sum > 12 || dice1 < 1 || dice1 > 6 || dice2 < 1 || dice2 > 6) begin
          failures++;
          $display("FAIL range: dice1=%0d dice2=%0d sum=%0d", dice1, dice2, sum);
        end
      end
    end
    reset = 0;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
